// File: rtl/noc_pkg.sv
// Shared types and XY routing for the mesh router.
// Output direction encodings equal the port indices they select.
package noc_pkg;

    localparam int PORT_N    = 0;
    localparam int PORT_S    = 1;
    localparam int PORT_E    = 2;
    localparam int PORT_W    = 3;
    localparam int PORT_L    = 4;
    localparam int NUM_PORTS = 5;

    // Coordinates are zero-extended to this width before comparison.
    localparam int MAX_ADDR_W = 8;

    typedef enum logic [2:0] {
        DIR_N = 3'(PORT_N),
        DIR_S = 3'(PORT_S),
        DIR_E = 3'(PORT_E),
        DIR_W = 3'(PORT_W),
        DIR_L = 3'(PORT_L)
    } dir_e;

    // Dimension-ordered routing: resolve X first, then Y, else eject locally.
    function automatic dir_e xy_route(
        input logic [MAX_ADDR_W-1:0] dest_x,
        input logic [MAX_ADDR_W-1:0] dest_y,
        input logic [MAX_ADDR_W-1:0] my_x,
        input logic [MAX_ADDR_W-1:0] my_y
    );
        dir_e dir;
        if (dest_x > my_x)      dir = DIR_E;
        else if (dest_x < my_x) dir = DIR_W;
        else if (dest_y > my_y) dir = DIR_N;
        else if (dest_y < my_y) dir = DIR_S;
        else                    dir = DIR_L;
        return dir;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Power-of-two circular input buffer with a combinational head output.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module router_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wr_en, rd_en;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the reset pointers and count already mark it empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/router_param.sv
// Five-port single-flit mesh router: input FIFOs, XY routing, per-output
// round-robin arbitration with credit flow control, and registered outputs.
module router_param
    import noc_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDIT_MAX = FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             my_x_i,
    input  logic [ADDR_W-1:0]             my_y_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   data_i,
    input  logic [NUM_PORTS-1:0]          valid_i,
    output logic [NUM_PORTS-1:0]          credit_o,
    output logic [NUM_PORTS*DATA_W-1:0]   data_o,
    output logic [NUM_PORTS-1:0]          valid_o,
    input  logic [NUM_PORTS-1:0]          credit_i,
    output logic [NUM_PORTS-1:0]          overflow_o
);

    localparam int CNT_W = $clog2(CREDIT_MAX + 1);
    localparam logic [CNT_W-1:0] CREDIT_INIT = CNT_W'(CREDIT_MAX);

    logic [NUM_PORTS-1:0]           fifo_full, fifo_empty, fifo_pop;
    logic [NUM_PORTS*DATA_W-1:0]    fifo_head;
    dir_e                           route [NUM_PORTS];
    // Bit o*NUM_PORTS+i set when output o grants input i.
    logic [NUM_PORTS*NUM_PORTS-1:0] grant_flat;
    logic [NUM_PORTS-1:0]           credit_o_q, credit_o_d;
    logic [NUM_PORTS-1:0]           overflow_q, overflow_d;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        router_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (valid_i[p]),
            .pop   (fifo_pop[p]),
            .wdata (data_i[p*DATA_W +: DATA_W]),
            .full  (fifo_full[p]),
            .empty (fifo_empty[p]),
            .head  (fifo_head[p*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            route[p] = xy_route(
                MAX_ADDR_W'(fifo_head[p*DATA_W + DATA_W - 1 -: ADDR_W]),
                MAX_ADDR_W'(fifo_head[p*DATA_W + DATA_W - 1 - ADDR_W -: ADDR_W]),
                MAX_ADDR_W'(my_x_i),
                MAX_ADDR_W'(my_y_i)
            );
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [NUM_PORTS-1:0] req, gnt;
        logic [2:0]           ptr_q, ptr_d, win;
        logic [3:0]           idx;
        logic                 found, eligible;
        logic [CNT_W-1:0]     cnt_q, cnt_d;
        logic [DATA_W-1:0]    data_q, data_d;
        logic                 valid_q, valid_d;

        // NOTE: every variable gets a default at the top of the block, so no path infers a latch.
        always_comb begin
            req      = '0;
            found    = 1'b0;
            win      = '0;
            idx      = '0;
            eligible = (cnt_q != '0) || credit_i[o];

            for (int i = 0; i < NUM_PORTS; i++) begin
                req[i] = !fifo_empty[i] && (route[i] == dir_e'(3'(o)));
            end

            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = {1'b0, ptr_q} + 4'(k);
                if (idx >= 4'(NUM_PORTS)) idx = idx - 4'(NUM_PORTS);
                if (eligible && !found && req[idx[2:0]]) begin
                    found = 1'b1;
                    win   = idx[2:0];
                end
            end

            gnt     = found ? (NUM_PORTS'(1) << win) : '0;
            valid_d = found;

            ptr_d = ptr_q;
            if (found) ptr_d = (win == 3'(NUM_PORTS - 1)) ? 3'd0 : win + 3'd1;

            data_d = data_q;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt[i]) data_d = fifo_head[i*DATA_W +: DATA_W];
            end

            // A send and a returning credit in the same cycle cancel out.
            cnt_d = cnt_q;
            if (found && !credit_i[o]) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else if (!found && credit_i[o] && (cnt_q != CREDIT_INIT)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ptr_q   <= '0;
                cnt_q   <= CREDIT_INIT;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                ptr_q   <= ptr_d;
                cnt_q   <= cnt_d;
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign data_o[o*DATA_W +: DATA_W]          = data_q;
        assign valid_o[o]                          = valid_q;
        assign grant_flat[o*NUM_PORTS +: NUM_PORTS] = gnt;
    end

    always_comb begin
        fifo_pop = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                fifo_pop[i] = fifo_pop[i] | grant_flat[o*NUM_PORTS + i];
            end
        end
        credit_o_d = fifo_pop;
        overflow_d = overflow_q | (valid_i & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_o_q <= '0;
            overflow_q <= '0;
        end else begin
            credit_o_q <= credit_o_d;
            overflow_q <= overflow_d;
        end
    end

    assign credit_o   = credit_o_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_router_param.sv
// Directed scenario bench for router_param at node (2,2) with 16-bit flits.
module tb_router_param;

    localparam int DW = 16;
    localparam int NP = 5;
    localparam int PN = 0;
    localparam int PS = 1;
    localparam int PE = 2;
    localparam int PW = 3;
    localparam int PL = 4;

    logic             clk;
    logic             rst;
    logic [2:0]       my_x, my_y;
    logic [NP*DW-1:0] data_i, data_o;
    logic [NP-1:0]    valid_i, credit_o, valid_o, credit_i, overflow_o;

    int passed;
    int total;

    router_param #(
        .DATA_W     (16),
        .ADDR_W     (3),
        .FIFO_DEPTH (4),
        .CREDIT_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .my_x_i     (my_x),
        .my_y_i     (my_y),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .credit_o   (credit_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .credit_i   (credit_i),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] flit(input int dx, input int dy, input int pl);
        logic [2:0] x;
        logic [2:0] y;
        logic [9:0] p;
        x = 3'(dx);
        y = 3'(dy);
        p = 10'(pl);
        return {x, y, p};
    endfunction

    function automatic logic [DW-1:0] dout(input int p);
        return data_o[p*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input logic [DW-1:0] f);
        data_i[p*DW +: DW] = f;
        valid_i[p]         = 1'b1;
    endtask

    task automatic idle();
        valid_i  = '0;
        credit_i = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Four sends from L to E leave the E credit counter at zero.
    task automatic exhaust_east();
        for (int j = 0; j < 4; j++) begin
            put(PL, flit(4, 0, 16'h100 + j));
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        tick();
        total++; if (valid_o !== 5'b0) $display("FAIL reset_valid: got %b expected %b", valid_o, 5'b0); else passed++;
        total++; if (data_o !== '0) $display("FAIL reset_data: got %h expected 0", data_o); else passed++;
        total++; if (credit_o !== 5'b0) $display("FAIL reset_credit: got %b expected %b", credit_o, 5'b0); else passed++;
        total++; if (overflow_o !== 5'b0) $display("FAIL reset_overflow: got %b expected %b", overflow_o, 5'b0); else passed++;
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        put(PL, 16'h8000);
        tick();
        idle();
        total++; if (valid_o !== 5'b0) $display("FAIL single_early: got %b expected %b", valid_o, 5'b0); else passed++;
        tick();
        total++; if (valid_o !== 5'b00100) $display("FAIL single_valid: got %b expected %b", valid_o, 5'b00100); else passed++;
        total++; if (dout(PE) !== 16'h8000) $display("FAIL single_data: got %h expected %h", dout(PE), 16'h8000); else passed++;
        total++; if (credit_o !== 5'b10000) $display("FAIL single_credit: got %b expected %b", credit_o, 5'b10000); else passed++;
        tick();
        total++; if ({valid_o, credit_o} !== 10'b0) $display("FAIL single_pulse_end: got %b expected %b", {valid_o, credit_o}, 10'b0); else passed++;
        total++; if (dout(PE) !== 16'h8000) $display("FAIL single_hold: got %h expected %h", dout(PE), 16'h8000); else passed++;
        // Three credits remain on E.
        for (int j = 0; j < 3; j++) begin
            put(PL, flit(4, 0, j + 1));
            tick();
            idle();
            tick();
            total++;
            if ({valid_o, dout(PE)} !== {5'b00100, flit(4, 0, j + 1)})
                $display("FAIL single_rest%0d: got %b/%h expected %b/%h", j, valid_o, dout(PE), 5'b00100, flit(4, 0, j + 1));
            else passed++;
        end
        put(PL, flit(4, 0, 9));
        tick();
        idle();
        for (int j = 0; j < 3; j++) begin
            tick();
            total++; if (valid_o !== 5'b0) $display("FAIL single_blocked%0d: got %b expected %b", j, valid_o, 5'b0); else passed++;
        end
        credit_i[PE] = 1'b1;
        tick();
        credit_i = '0;
        total++;
        if ({valid_o, dout(PE)} !== {5'b00100, flit(4, 0, 9)})
            $display("FAIL single_bypass: got %b/%h expected %b/%h", valid_o, dout(PE), 5'b00100, flit(4, 0, 9));
        else passed++;
    endtask

    task automatic test_arbitration();
        logic [DW-1:0] exp_d [5];
        logic [NP-1:0] exp_c [5];
        exp_d[0] = flit(2, 2, 1);  exp_c[0] = 5'b00001;
        exp_d[1] = flit(2, 2, 17); exp_c[1] = 5'b00010;
        exp_d[2] = flit(2, 2, 49); exp_c[2] = 5'b01000;
        exp_d[3] = flit(2, 2, 2);  exp_c[3] = 5'b00001;
        exp_d[4] = flit(2, 2, 3);  exp_c[4] = 5'b00001;
        do_reset();
        put(PN, flit(2, 2, 1));
        put(PS, flit(2, 2, 17));
        put(PW, flit(2, 2, 49));
        tick();
        for (int j = 0; j < 4; j++) begin
            idle();
            if (j == 0) put(PN, flit(2, 2, 2));
            if (j == 1) put(PN, flit(2, 2, 3));
            tick();
            total++;
            if ({valid_o, dout(PL), credit_o} !== {5'b10000, exp_d[j], exp_c[j]})
                $display("FAIL arb_grant%0d: got %b/%h/%b expected %b/%h/%b", j, valid_o, dout(PL), credit_o, 5'b10000, exp_d[j], exp_c[j]);
            else passed++;
        end
        idle();
        for (int j = 0; j < 3; j++) begin
            tick();
            total++; if (valid_o !== 5'b0) $display("FAIL arb_stall%0d: got %b expected %b", j, valid_o, 5'b0); else passed++;
        end
        credit_i[PL] = 1'b1;
        tick();
        credit_i = '0;
        total++;
        if ({valid_o, dout(PL), credit_o} !== {5'b10000, exp_d[4], exp_c[4]})
            $display("FAIL arb_credit_grant: got %b/%h/%b expected %b/%h/%b", valid_o, dout(PL), credit_o, 5'b10000, exp_d[4], exp_c[4]);
        else passed++;
        tick();
        total++; if (valid_o !== 5'b0) $display("FAIL arb_after_credit: got %b expected %b", valid_o, 5'b0); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        exhaust_east();
        for (int j = 0; j < 5; j++) begin
            put(PW, flit(4, 1, 16'h40 + j));
            tick();
            if (j == 3) begin
                total++; if (overflow_o !== 5'b0) $display("FAIL ovf_at_full: got %b expected %b", overflow_o, 5'b0); else passed++;
            end
        end
        idle();
        total++; if (overflow_o !== 5'b01000) $display("FAIL ovf_set: got %b expected %b", overflow_o, 5'b01000); else passed++;
        credit_i[PE] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            total++;
            if ({valid_o, dout(PE), credit_o} !== {5'b00100, flit(4, 1, 16'h40 + j), 5'b01000})
                $display("FAIL ovf_drain%0d: got %b/%h/%b expected %b/%h/%b", j, valid_o, dout(PE), credit_o, 5'b00100, flit(4, 1, 16'h40 + j), 5'b01000);
            else passed++;
        end
        tick();
        credit_i = '0;
        total++; if (valid_o !== 5'b0) $display("FAIL ovf_dropped: got %b expected %b", valid_o, 5'b0); else passed++;
        tick();
        total++; if (overflow_o !== 5'b01000) $display("FAIL ovf_sticky: got %b expected %b", overflow_o, 5'b01000); else passed++;
    endtask

    task automatic test_credit();
        do_reset();
        // Credit return at the maximum must saturate at 4.
        credit_i[PE] = 1'b1;
        tick();
        credit_i = '0;
        for (int j = 0; j < 3; j++) begin
            put(PL, flit(5, 3, j));
            tick();
        end
        idle();
        tick();
        tick();
        // Counter is 1: send and credit_i together keep it at 1.
        put(PL, flit(5, 3, 4));
        tick();
        idle();
        credit_i[PE] = 1'b1;
        tick();
        credit_i = '0;
        total++;
        if ({valid_o, dout(PE)} !== {5'b00100, flit(5, 3, 4)})
            $display("FAIL credit_simul: got %b/%h expected %b/%h", valid_o, dout(PE), 5'b00100, flit(5, 3, 4));
        else passed++;
        put(PL, flit(5, 3, 5));
        tick();
        idle();
        tick();
        total++;
        if ({valid_o, dout(PE)} !== {5'b00100, flit(5, 3, 5)})
            $display("FAIL credit_last: got %b/%h expected %b/%h", valid_o, dout(PE), 5'b00100, flit(5, 3, 5));
        else passed++;
        put(PL, flit(5, 3, 6));
        tick();
        idle();
        for (int j = 0; j < 2; j++) begin
            tick();
            total++; if (valid_o !== 5'b0) $display("FAIL credit_empty%0d: got %b expected %b", j, valid_o, 5'b0); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [NP-1:0] seen;
        do_reset();
        exhaust_east();
        for (int j = 0; j < 3; j++) begin
            put(PW, flit(4, 2, 16'h50 + j));
            tick();
        end
        idle();
        put(PN, flit(2, 0, 16'h60));
        tick();
        idle();
        tick();
        total++;
        if ({valid_o, credit_o} !== {5'b00010, 5'b00001})
            $display("FAIL rstmid_pre: got %b/%b expected %b/%b", valid_o, credit_o, 5'b00010, 5'b00001);
        else passed++;
        #3;
        rst = 1'b0;
        #1;
        total++; if ({valid_o, credit_o} !== 10'b0) $display("FAIL rstmid_async: got %b/%b expected 0/0", valid_o, credit_o); else passed++;
        total++; if (data_o !== '0) $display("FAIL rstmid_data: got %h expected 0", data_o); else passed++;
        tick();
        rst = 1'b1;
        seen = '0;
        for (int j = 0; j < 6; j++) begin
            tick();
            seen = seen | valid_o;
        end
        total++; if (seen !== 5'b0) $display("FAIL rstmid_stale: got %b expected %b", seen, 5'b0); else passed++;
        for (int j = 0; j < 5; j++) begin
            put(PL, flit(4, 3, j));
            tick();
            if (j >= 1) begin
                total++;
                if ({valid_o, dout(PE)} !== {5'b00100, flit(4, 3, j - 1)})
                    $display("FAIL rstmid_credit%0d: got %b/%h expected %b/%h", j, valid_o, dout(PE), 5'b00100, flit(4, 3, j - 1));
                else passed++;
            end
        end
        idle();
        tick();
        total++; if (valid_o !== 5'b0) $display("FAIL rstmid_fifth: got %b expected %b", valid_o, 5'b0); else passed++;
    endtask

    task automatic test_route();
        do_reset();
        put(PE, flit(2, 2, 16'h71));
        put(PS, flit(2, 5, 16'h72));
        tick();
        idle();
        tick();
        total++; if (valid_o !== 5'b10001) $display("FAIL route_valid: got %b expected %b", valid_o, 5'b10001); else passed++;
        total++; if (dout(PL) !== flit(2, 2, 16'h71)) $display("FAIL route_local: got %h expected %h", dout(PL), flit(2, 2, 16'h71)); else passed++;
        total++; if (dout(PN) !== flit(2, 5, 16'h72)) $display("FAIL route_north: got %h expected %h", dout(PN), flit(2, 5, 16'h72)); else passed++;
        total++; if (credit_o !== 5'b00110) $display("FAIL route_credit: got %b expected %b", credit_o, 5'b00110); else passed++;
        // U-turns, unsigned compares and the south direction.
        put(PN, flit(2, 7, 16'h73));
        put(PW, flit(0, 3, 16'h74));
        put(PL, flit(7, 2, 16'h75));
        put(PS, flit(2, 1, 16'h76));
        tick();
        idle();
        tick();
        total++; if (valid_o !== 5'b01111) $display("FAIL route2_valid: got %b expected %b", valid_o, 5'b01111); else passed++;
        total++;
        if ({dout(PN), dout(PS), dout(PE), dout(PW)} !== {flit(2, 7, 16'h73), flit(2, 1, 16'h76), flit(7, 2, 16'h75), flit(0, 3, 16'h74)})
            $display("FAIL route2_data: got %h %h %h %h expected %h %h %h %h", dout(PN), dout(PS), dout(PE), dout(PW),
                     flit(2, 7, 16'h73), flit(2, 1, 16'h76), flit(7, 2, 16'h75), flit(0, 3, 16'h74));
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        passed  = 0;
        total   = 0;
        my_x    = 3'd2;
        my_y    = 3'd2;
        data_i  = '0;
        valid_i = '0;
        credit_i = '0;
        rst     = 1'b0;
        test_reset();
        test_single();
        test_arbitration();
        test_overflow();
        test_credit();
        test_reset_mid();
        test_route();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
